// File: rtl/dom1_skinny_pkg.sv
// rtl/dom1_skinny_pkg.sv - shared types, sizes and share-wise linear layers for the masked inverse SKINNY round
package dom1_skinny_pkg;

    localparam int STAGES  = 4;
    localparam int STATE_W = 128;
    localparam int SBOX_N  = 16;

    // OUT is only reachable when the output register build option is enabled
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        OUT  = 3'd4,
        DONE = 3'd5
    } state_t;

    // Inverse MixColumns on one share; R0 occupies the top 32 bits
    function automatic logic [STATE_W-1:0] inv_mix_columns(input logic [STATE_W-1:0] x);
        logic [31:0] r0, r1, r2, r3;
        r0 = x[127:96];
        r1 = x[95:64];
        r2 = x[63:32];
        r3 = x[31:0];
        return {r1, r2 ^ r3 ^ r1, r3 ^ r1, r0 ^ r3};
    endfunction

    // Inverse ShiftRows on one share; row i rotates left by i bytes
    function automatic logic [STATE_W-1:0] inv_shift_rows(input logic [STATE_W-1:0] x);
        return {x[127:96],
                x[87:64], x[95:88],
                x[47:32], x[63:48],
                x[7:0],   x[31:8]};
    endfunction

endpackage

// File: rtl/dom1_inv_sbox8.sv
// rtl/dom1_inv_sbox8.sv - one masked inverse SKINNY 8-bit sbox, four registered DOM-indep gadget stages
module dom1_inv_sbox8
    import dom1_skinny_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] en,
    input  logic [7:0]        y0,
    input  logic [7:0]        y1,
    input  logic [7:0]        r,
    output logic [7:0]        b0,
    output logic [7:0]        b1
);

    // Masked g(x,c,z) = (x NOR c) ^ z as (~x)&(~c)^z. Complementing only share 0
    // of each operand negates it. Result packs {inner0, cross0, inner1, cross1};
    // every product term is registered before shares are summed.
    function automatic logic [3:0] gadget(input logic x0, input logic x1,
                                          input logic c0, input logic c1,
                                          input logic z0, input logic z1,
                                          input logic rnd);
        logic a0, d0;
        a0 = ~x0;
        d0 = ~c0;
        return {(a0 & d0) ^ z0, (a0 & c1) ^ rnd, (x1 & c1) ^ z1, (x1 & d0) ^ rnd};
    endfunction

    logic [7:0][3:0] g_q;
    logic [7:0][3:0] g_d;
    // Carried y bits per share: [0]=y2 [1]=y3 [2]=y5 [3]=y6
    logic [3:0]      yc0_q;
    logic [3:0]      yc1_q;
    // Latched randomness for later stages: [0]=r0 [1]=r1 [2]=r4 [3]=r6
    logic [3:0]      rl_q;

    // Output shares: each gadget compresses its registered terms within its own domain
    always_comb begin
        b0 = '0;
        b1 = '0;
        for (int k = 0; k < 8; k++) begin
            b0[k] = g_q[k][3] ^ g_q[k][2];
            b1[k] = g_q[k][1] ^ g_q[k][0];
        end
    end

    // Gadget inputs: stage 1 from the live byte, later stages from registered outputs and carries
    always_comb begin
        g_d    = '0;
        g_d[2] = gadget(y0[3], y1[3], y0[1], y1[1], y0[0], y1[0], r[2]);
        g_d[3] = gadget(y0[7], y1[7], y0[6], y1[6], y0[4], y1[4], r[3]);
        g_d[7] = gadget(y0[2], y1[2], y0[7], y1[7], y0[1], y1[1], r[7]);
        g_d[5] = gadget(y0[6], y1[6], y0[5], y1[5], y0[7], y1[7], r[5]);
        g_d[1] = gadget(yc0_q[2], yc1_q[2], b0[3], b1[3], yc0_q[1], yc1_q[1], rl_q[1]);
        g_d[0] = gadget(b0[3], b1[3], b0[2], b1[2], yc0_q[2], yc1_q[2], rl_q[0]);
        g_d[6] = gadget(b0[2], b1[2], b0[1], b1[1], yc0_q[0], yc1_q[0], rl_q[3]);
        g_d[4] = gadget(b0[7], b1[7], b0[6], b1[6], yc0_q[3], yc1_q[3], rl_q[2]);
    end

    // Stage registers; each group loads only on its enable and otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q   <= '0;
            yc0_q <= '0;
            yc1_q <= '0;
            rl_q  <= '0;
        end else begin
            if (en[0]) begin
                g_q[2] <= g_d[2];
                g_q[3] <= g_d[3];
                g_q[7] <= g_d[7];
                g_q[5] <= g_d[5];
                yc0_q  <= {y0[6], y0[5], y0[3], y0[2]};
                yc1_q  <= {y1[6], y1[5], y1[3], y1[2]};
                rl_q   <= {r[6], r[4], r[1], r[0]};
            end
            if (en[1]) begin
                g_q[1] <= g_d[1];
                g_q[0] <= g_d[0];
            end
            if (en[2]) begin
                g_q[6] <= g_d[6];
            end
            if (en[3]) begin
                g_q[4] <= g_d[4];
            end
        end
    end

endmodule

// File: rtl/dom1_skinny_inv_rnd.sv
// rtl/dom1_skinny_inv_rnd.sv - masked inverse SKINNY-128-384+ round on two DOM shares (option: DOM1_SKINNY_INV_RND_OUTREG_EN)
module dom1_skinny_inv_rnd
    import dom1_skinny_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] sshi0,
    input  logic [STATE_W-1:0] sshi1,
    input  logic [STATE_W-1:0] ksh0,
    input  logic [STATE_W-1:0] ksh1,
    input  logic [STATE_W-1:0] r,
    output logic [STATE_W-1:0] ssho0,
    output logic [STATE_W-1:0] ssho1,
    output logic               busy,
    output logic               done
);

    state_t             state_q;
    state_t             state_d;
    logic [STAGES-1:0]  stage_en;
    logic [STATE_W-1:0] y0;
    logic [STATE_W-1:0] y1;
    logic [STATE_W-1:0] sb0;
    logic [STATE_W-1:0] sb1;

    // Linear layers are applied to each share independently
    assign y0 = inv_shift_rows(inv_mix_columns(sshi0)) ^ ksh0;
    assign y1 = inv_shift_rows(inv_mix_columns(sshi1)) ^ ksh1;

    for (genvar i = 0; i < SBOX_N; i++) begin : g_sbox
        dom1_inv_sbox8 u_sbox (
            .clk (clk),
            .rst (rst),
            .en  (stage_en),
            .y0  (y0[8*i +: 8]),
            .y1  (y1[8*i +: 8]),
            .r   (r[8*i +: 8]),
            .b0  (sb0[8*i +: 8]),
            .b1  (sb1[8*i +: 8])
        );
    end

`ifdef DOM1_SKINNY_INV_RND_OUTREG_EN
    logic               out_en;
    logic [STATE_W-1:0] out0_q;
    logic [STATE_W-1:0] out1_q;

    // Output register decouples the shares from the stage registers until the next result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out0_q <= '0;
            out1_q <= '0;
        end else if (out_en) begin
            out0_q <= sb0;
            out1_q <= sb1;
        end
    end

    assign ssho0 = out0_q;
    assign ssho1 = out1_q;
`else
    assign ssho0 = sb0;
    assign ssho1 = sb1;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencing: accept only in IDLE/DONE, then one gadget stage per cycle
    always_comb begin
        state_d  = state_q;
        stage_en = '0;
        busy     = 1'b0;
        done     = 1'b0;
`ifdef DOM1_SKINNY_INV_RND_OUTREG_EN
        out_en   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    stage_en[0] = 1'b1;
                    state_d     = S1;
                end
            end
            S1: begin
                busy        = 1'b1;
                stage_en[1] = 1'b1;
                state_d     = S2;
            end
            S2: begin
                busy        = 1'b1;
                stage_en[2] = 1'b1;
                state_d     = S3;
            end
            S3: begin
                busy        = 1'b1;
                stage_en[3] = 1'b1;
`ifdef DOM1_SKINNY_INV_RND_OUTREG_EN
                state_d     = OUT;
`else
                state_d     = DONE;
`endif
            end
`ifdef DOM1_SKINNY_INV_RND_OUTREG_EN
            OUT: begin
                busy    = 1'b1;
                out_en  = 1'b1;
                state_d = DONE;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) begin
                    stage_en[0] = 1'b1;
                    state_d     = S1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dom1_skinny_inv_rnd.sv
// tb/tb_dom1_skinny_inv_rnd.sv - self-checking bench for the masked inverse SKINNY round
module tb_dom1_skinny_inv_rnd;

`ifdef DOM1_SKINNY_INV_RND_OUTREG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [127:0] sshi0 = '0;
    logic [127:0] sshi1 = '0;
    logic [127:0] ksh0  = '0;
    logic [127:0] ksh1  = '0;
    logic [127:0] r     = '0;
    logic [127:0] ssho0;
    logic [127:0] ssho1;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;

    logic [7:0] inv_tbl [256];
    logic [7:0] fwd_tbl [256];

    dom1_skinny_inv_rnd dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sshi0 (sshi0),
        .sshi1 (sshi1),
        .ksh0  (ksh0),
        .ksh1  (ksh1),
        .r     (r),
        .ssho0 (ssho0),
        .ssho1 (ssho1),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] inv_sbox_formula(input logic [7:0] y);
        logic [7:0] b;
        b[2] = ~(y[3] | y[1]) ^ y[0];
        b[3] = ~(y[7] | y[6]) ^ y[4];
        b[7] = ~(y[2] | y[7]) ^ y[1];
        b[5] = ~(y[6] | y[5]) ^ y[7];
        b[1] = ~(y[5] | b[3]) ^ y[3];
        b[0] = ~(b[3] | b[2]) ^ y[5];
        b[6] = ~(b[2] | b[1]) ^ y[2];
        b[4] = ~(b[7] | b[6]) ^ y[6];
        return b;
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] w, input int n);
        if (n == 0) return w;
        return (w << n) | (w >> (32 - n));
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Unmasked inverse round: rows, then byte rotations, key, table lookup
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k);
        logic [31:0]  a [4];
        logic [31:0]  m [4];
        logic [127:0] t;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) a[i] = s[127-32*i -: 32];
        m[0] = a[1];
        m[1] = a[2] ^ a[3] ^ a[1];
        m[2] = a[3] ^ a[1];
        m[3] = a[0] ^ a[3];
        for (int i = 0; i < 4; i++) m[i] = rol(m[i], 8*i);
        t = {m[0], m[1], m[2], m[3]} ^ k;
        o = '0;
        for (int b = 0; b < 16; b++) o[8*b +: 8] = inv_tbl[t[8*b +: 8]];
        return o;
    endfunction

    // Forward round: SubCells, AddTweakey, ShiftRows, MixColumns
    function automatic logic [127:0] fwd_round(input logic [127:0] p, input logic [127:0] k);
        logic [31:0]  a [4];
        logic [127:0] t;
        t = '0;
        for (int b = 0; b < 16; b++) t[8*b +: 8] = fwd_tbl[p[8*b +: 8]];
        t = t ^ k;
        for (int i = 0; i < 4; i++) a[i] = rol(t[127-32*i -: 32], (32 - 8*i) % 32);
        return {a[3] ^ a[2] ^ a[0], a[0], a[1] ^ a[2], a[2] ^ a[0]};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one operation, scramble inputs after the accept edge, wait for done
    task automatic run_op(input logic [127:0] a0, input logic [127:0] a1,
                          input logic [127:0] k0, input logic [127:0] k1,
                          input logic [127:0] rr, output int lat);
        @(negedge clk);
        sshi0 = a0; sshi1 = a1; ksh0 = k0; ksh1 = k1; r = rr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sshi0 = rnd128(); sshi1 = rnd128(); ksh0 = rnd128(); ksh1 = rnd128(); r = rnd128();
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int           lat;
        logic [127:0] k65, kff, m, km, s, k, p, c, sa, ka, sc, kc, sd, kd;

        k65 = {16{8'h65}};
        kff = {16{8'hFF}};
        for (int v = 0; v < 256; v++) inv_tbl[v] = inv_sbox_formula(8'(v));
        for (int v = 0; v < 256; v++) fwd_tbl[inv_tbl[v]] = 8'(v);

        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_ssho0", ssho0, 128'd0);
        check("rst_ssho1", ssho1, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // All-zero state with 0x65 key recombines to zero
        run_op('0, '0, k65, '0, '0, lat);
        check("lat_k65", 128'(lat), 128'(LAT));
        check("xor_k65", ssho0 ^ ssho1, 128'd0);
        @(posedge clk); #1;
        check("done_pulse", {127'd0, done}, 128'd0);

        // 0xFF key, then random splits and randomness give the same unmasked value
        run_op('0, '0, kff, '0, '0, lat);
        check("xor_kff", ssho0 ^ ssho1, kff);
        for (int i = 0; i < 6; i++) begin
            m  = rnd128();
            km = rnd128();
            run_op(m, m, kff ^ km, km, rnd128(), lat);
            check("xor_kff_split", ssho0 ^ ssho1, kff);
            check("lat_kff_split", 128'(lat), 128'(LAT));
        end
        repeat (3) @(posedge clk);
        #1;
        check("hold_xor", ssho0 ^ ssho1, kff);
        check("hold_busy", {127'd0, busy}, 128'd0);

        // Random state and key against the reference model
        for (int i = 0; i < 20; i++) begin
            s  = rnd128();
            k  = rnd128();
            m  = rnd128();
            km = rnd128();
            run_op(s ^ m, m, k ^ km, km, rnd128(), lat);
            check("ref_rand", ssho0 ^ ssho1, inv_round(s, k));
        end

        // start during S1..S3 is ignored; start in DONE re-enters S1
        sa = rnd128();
        ka = rnd128();
        @(negedge clk);
        sshi0 = sa; sshi1 = '0; ksh0 = ka; ksh1 = '0; r = rnd128(); start = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            sshi0 = rnd128(); ksh0 = rnd128(); start = 1'b1;
            check("busy_mid", {127'd0, busy}, 128'd1);
            check("done_mid", {127'd0, done}, 128'd0);
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
        end
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("lat_ignore", 128'(lat), 128'(LAT));
        check("xor_ignore", ssho0 ^ ssho1, inv_round(sa, ka));
        sc = rnd128();
        kc = rnd128();
        m  = rnd128();
        sshi0 = sc ^ m; sshi1 = m; ksh0 = kc; ksh1 = '0; r = rnd128(); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_from_done", {127'd0, busy}, 128'd1);
        check("done_single", {127'd0, done}, 128'd0);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("lat_from_done", 128'(lat), 128'(LAT));
        check("xor_from_done", ssho0 ^ ssho1, inv_round(sc, kc));

        // Reset in S2 aborts immediately; the next operation is clean
        sd = rnd128();
        kd = rnd128();
        @(negedge clk);
        sshi0 = sd; sshi1 = '0; ksh0 = kd; ksh1 = '0; r = rnd128(); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_busy", {127'd0, busy}, 128'd0);
        check("abort_done", {127'd0, done}, 128'd0);
        check("abort_ssho0", ssho0, 128'd0);
        check("abort_ssho1", ssho1, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        m  = rnd128();
        km = rnd128();
        run_op(sd ^ m, m, kd ^ km, km, rnd128(), lat);
        check("lat_after_abort", 128'(lat), 128'(LAT));
        check("xor_after_abort", ssho0 ^ ssho1, inv_round(sd, kd));

        // Round trip: forward round with K, then this block with K returns the plaintext
        for (int i = 0; i < 1000; i++) begin
            p  = rnd128();
            k  = rnd128();
            c  = fwd_round(p, k);
            m  = rnd128();
            km = rnd128();
            run_op(c ^ m, m, k ^ km, km, rnd128(), lat);
            check("roundtrip", ssho0 ^ ssho1, p);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dom1_skinny_inv_rnd.md
DOM1_SKINNY_INV_RND -- requirements
Module: dom1_skinny_inv_rnd

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all flops rising-edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports start (input, 1, request pulse), sshi0/sshi1 (input, 128, masked state shares), ksh0/ksh1 (input, 128, tweakey shares incl. round constants).
REQ-004 SHALL have port r, input, 128, fresh randomness; bit 8i+k feeds gadget k of sbox i.
REQ-005 SHALL have ports ssho0/ssho1 (output, 128, inverse-round shares), busy (output, 1), done (output, 1, one-cycle pulse).

Function
REQ-006 SHALL compute one inverse SKINNY-128-384+ round on two DOM shares, share-wise linear, masked nonlinear: InvMixColumns, InvShiftRows, AddTweakey, InvSbox, in that order.
REQ-007 InvMixColumns per share, rows R0=[127:96], R1=[95:64], R2=[63:32], R3=[31:0]: R0'=R1; R2'=R3^R1; R1'=R2^R3^R1; R3'=R0^R3.
REQ-008 InvShiftRows per share: row0 unchanged; row1 {x[87:64],x[95:88]}; row2 {x[47:32],x[63:48]}; row3 {x[7:0],x[31:8]}.
REQ-009 AddTweakey: share j XOR kshj, no randomness.
REQ-010 InvSbox per byte: 16 instances, 8 masked gadgets g(x,y,z)=(x NOR y)^z, each DOM-indep, all products registered, fresh bit per gadget; y = input byte, b = output byte.
REQ-011 Stage 1 (accept edge): b2=g(y3,y1,y0), b3=g(y7,y6,y4), b7=g(y2,y7,y1), b5=g(y6,y5,y7).
REQ-012 Stage 2: b1=g(y5,b3,y3), b0=g(b3,b2,y5); stage 3: b6=g(b2,b1,y2); stage 4: b4=g(b7,b6,y6).
REQ-013 y bits used as z after stage 1 SHALL be carried in share-wise registers, never recombined.
REQ-014 FSM states IDLE, S1, S2, S3, DONE; IDLE--start-->S1 (stage-1 capture on that edge), S1->S2->S3->DONE unconditionally, DONE->IDLE, or DONE->S1 if start.
REQ-015 start SHALL be sampled only in IDLE or DONE; start in S1..S3 ignored, no queuing.
REQ-016 sshi*, ksh*, r SHALL be sampled only on the accept edge; r bits for stages 2-4 latched then.
REQ-017 busy=1 in S1..S3; done=1 only in DONE; latency accept edge to done high = 4 cycles.
REQ-018 ssho* SHALL hold their value from DONE until the next accepted start completes.
REQ-019 Unmasked result (ssho0^ssho1) SHALL be independent of share split and r.

Reset
REQ-020 rst SHALL force IDLE, busy=0, done=0, ssho0=ssho1=0, all gadget/carry/randomness registers 0, asynchronously.
REQ-021 rst mid-operation SHALL abort; first start after release behaves as from power-up.

Configuration
REQ-022 Macro DOM1_SKINNY_INV_RND_OUTREG_EN: defined -> extra 256-bit output register, state OUT after S3, latency 5, done in cycle after OUT capture; undefined -> ssho* driven from stage registers, latency 4.

Structure
REQ-023 Package dom1_skinny_pkg SHALL hold state enum, STAGES=4, STATE_W=128, SBOX_N=16.
REQ-024 Sub-module dom1_inv_sbox8 (one byte, 4-stage, resettable gadgets, stage enables from parent FSM) SHALL be the only sub-module.

Verification
REQ-025 sshi0=sshi1=0, ksh0=all 0x65, ksh1=0, r=0, start -> done at +4, ssho0^ssho1 = 0.
REQ-026 Same as REQ-025 with ksh0=all 0xFF -> ssho0^ssho1 = all 0xFF; repeated with random share split and random r -> identical XOR.
REQ-027 Random plaintext shares through forward masked round with key K, outputs into this block with K -> recombined output equals original plaintext, 1000 vectors.
REQ-028 start asserted in S1, S2, S3 -> ignored, busy stays, single done pulse; start in DONE -> S1 next edge.
REQ-029 rst asserted in S2 -> outputs 0, busy=0 immediately; next start yields correct result at +4.
REQ-030 With DOM1_SKINNY_INV_RND_OUTREG_EN -> REQ-025 vector gives done at +5, same data.
